// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer/flag controller for an async FIFO: binary write pointer,
// registered Gray export, full/almost_full/level from the synchronized read pointer.
// Optional sticky overflow flag built only when FIFO_WR_OVERFLOW_EN is defined.
module fifo_wr_ptr_ctrl #(
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_inc,
  input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  // Full when Gray write pointer equals read pointer with its top two bits inverted.
  localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};
  localparam logic [PW-1:0] AFULL_T   = PW'(AFULL_THRESH);

  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic [PW-1:0] rd_bin;

  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < PW; i++) rd_bin[i] = ^(rd_ptr_sync >> i);
  end

  assign wr_en = wr_inc & ~full_q;

  always_comb begin
    wr_bin_d = wr_en ? wr_bin_q + PW'(1) : wr_bin_q;
    gray_d   = wr_bin_d ^ (wr_bin_d >> 1);
    full_d   = (gray_d == (rd_ptr_sync ^ FULL_MASK));
    level_d  = wr_bin_d - rd_bin;
    afull_d  = (level_d >= AFULL_T);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_bin_q <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_bin_q <= wr_bin_d;
      gray_q   <= gray_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

`ifdef FIFO_WR_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb overflow_d = overflow_q | (wr_inc & full_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) overflow_q <= 1'b0;
    else      overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign wr_addr     = wr_bin_q[ADDR_WIDTH-1:0];
  assign wr_ptr_gray = gray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_level    = level_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Directed bench for fifo_wr_ptr_ctrl at ADDR_WIDTH=3, AFULL_THRESH=6:
// reset, fill, write-while-full, drain, wrap and mid-operation reset.
module tb_fifo_wr_ptr_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wr_inc = 1'b0;
  logic [3:0] rd_ptr_sync = '0;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr_gray;
  logic       full, almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  // Hand-written 4-bit Gray sequence for binary 0..15.
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

`ifdef FIFO_WR_OVERFLOW_EN
  logic exp_ovf = 1'b1;
`else
  logic exp_ovf = 1'b0;
`endif

  fifo_wr_ptr_ctrl #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
    .CLK(CLK), .RST(RST), .wr_inc(wr_inc), .rd_ptr_sync(rd_ptr_sync),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_ptr_gray(wr_ptr_gray),
    .full(full), .almost_full(almost_full), .wr_level(wr_level),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    tick();
    #2;
    RST = 1'b0;
    #1;
    total++; if (wr_addr !== 3'd0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", wr_addr); end
    total++; if (wr_ptr_gray !== 4'h0) begin bad++; $display("FAIL reset_gray got=%0h exp=0", wr_ptr_gray); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    total++; if (wr_level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", wr_level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    wr_inc = 1'b1; #1;
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL reset_wren_hi got=%b exp=1", wr_en); end
    wr_inc = 1'b0; #1;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wren_lo got=%b exp=0", wr_en); end
    tick();
    RST = 1'b1;
  endtask

  task automatic test_fill();
    rd_ptr_sync = 4'h0;
    wr_inc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL fill_wren[%0d] got=%b exp=1", i, wr_en); end
      tick();
      total++; if (wr_ptr_gray !== gtab[i+1]) begin bad++; $display("FAIL fill_gray[%0d] got=%0h exp=%0h", i, wr_ptr_gray, gtab[i+1]); end
      total++; if (wr_level !== 4'(i+1)) begin bad++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, wr_level, i+1); end
      total++; if (wr_addr !== 3'(i+1)) begin bad++; $display("FAIL fill_addr[%0d] got=%0d exp=%0d", i, wr_addr, (i+1)%8); end
      total++; if (almost_full !== (i >= 5)) begin bad++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, almost_full, i >= 5); end
      total++; if (full !== (i == 7)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 7); end
    end
  endtask

  task automatic test_write_while_full();
    wr_inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL wwf_wren[%0d] got=%b exp=0", i, wr_en); end
      tick();
      total++; if (wr_addr !== 3'd0) begin bad++; $display("FAIL wwf_addr[%0d] got=%0d exp=0", i, wr_addr); end
      total++; if (wr_ptr_gray !== 4'hC) begin bad++; $display("FAIL wwf_gray[%0d] got=%0h exp=c", i, wr_ptr_gray); end
      total++; if (full !== 1'b1) begin bad++; $display("FAIL wwf_full[%0d] got=%b exp=1", i, full); end
      total++; if (wr_level !== 4'd8) begin bad++; $display("FAIL wwf_level[%0d] got=%0d exp=8", i, wr_level); end
      total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL wwf_ovf[%0d] got=%b exp=%b", i, overflow, exp_ovf); end
    end
  endtask

  task automatic test_drain();
    wr_inc = 1'b0;
    rd_ptr_sync = 4'b0010;
    tick();
    total++; if (full !== 1'b0) begin bad++; $display("FAIL drain_full got=%b exp=0", full); end
    total++; if (wr_level !== 4'd5) begin bad++; $display("FAIL drain_level got=%0d exp=5", wr_level); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL drain_afull got=%b exp=0", almost_full); end
    total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL drain_ovf got=%b exp=%b", overflow, exp_ovf); end
  endtask

  task automatic test_wrap();
    int b;
    #2; RST = 1'b0; #2; RST = 1'b1;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL wrap_ovf_clr got=%b exp=0", overflow); end
    rd_ptr_sync = 4'h0;
    wr_inc = 1'b1;
    tick(); tick();
    total++; if (wr_level !== 4'd2) begin bad++; $display("FAIL wrap_prime got=%0d exp=2", wr_level); end
    b = 2;
    for (int i = 0; i < 20; i++) begin
      rd_ptr_sync = gtab[(b + 15) % 16];
      tick();
      b = (b + 1) % 16;
      total++; if (wr_ptr_gray !== gtab[b]) begin bad++; $display("FAIL wrap_gray[%0d] got=%0h exp=%0h", i, wr_ptr_gray, gtab[b]); end
      total++; if (wr_level !== 4'd2) begin bad++; $display("FAIL wrap_level[%0d] got=%0d exp=2", i, wr_level); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL wrap_full[%0d] got=%b exp=0", i, full); end
      total++; if (wr_addr !== 3'(b)) begin bad++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", i, wr_addr, b % 8); end
    end
  endtask

  task automatic test_reset_mid();
    #2; RST = 1'b0; #2; RST = 1'b1;
    rd_ptr_sync = 4'h0;
    wr_inc = 1'b1;
    repeat (5) tick();
    total++; if (wr_ptr_gray !== 4'h7) begin bad++; $display("FAIL mid_pre_gray got=%0h exp=7", wr_ptr_gray); end
    #2;
    RST = 1'b0;
    #1;
    total++; if (wr_addr !== 3'd0) begin bad++; $display("FAIL mid_addr got=%0d exp=0", wr_addr); end
    total++; if (wr_ptr_gray !== 4'h0) begin bad++; $display("FAIL mid_gray got=%0h exp=0", wr_ptr_gray); end
    total++; if (wr_level !== 4'd0) begin bad++; $display("FAIL mid_level got=%0d exp=0", wr_level); end
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL mid_wren got=%b exp=1", wr_en); end
    #1;
    RST = 1'b1;
    tick();
    total++; if (wr_ptr_gray !== 4'h1) begin bad++; $display("FAIL mid_post_gray got=%0h exp=1", wr_ptr_gray); end
    total++; if (wr_addr !== 3'd1) begin bad++; $display("FAIL mid_post_addr got=%0d exp=1", wr_addr); end
    total++; if (wr_level !== 4'd1) begin bad++; $display("FAIL mid_post_level got=%0d exp=1", wr_level); end
    wr_inc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_while_full();
    test_drain();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ptr_ctrl.md
# fifo_wr_ptr_ctrl

Write-side pointer and flag controller for the asynchronous FIFO. It runs entirely in the write clock domain and advances a binary write pointer on accepted writes. It publishes that pointer Gray-encoded and registered, so the two-flop synchronizer can carry it into the read domain. It also decodes the already-synchronized Gray read pointer to generate full, almost-full, fill level and overflow status for the writer.

## Interface
- ADDR_WIDTH, 3, FIFO memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 6, fill level at or above which almost_full asserts; legal range 1..2^ADDR_WIDTH.
- CLK  input  1  write-domain clock; all state on rising edge.
- RST  input  1  asynchronous, active-low reset.
- wr_inc  input  1  write request from producer, sampled each CLK.
- rd_ptr_sync  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into CLK domain.
- wr_en  output  1  memory write strobe, combinational: wr_inc & ~full.
- wr_addr  output  ADDR_WIDTH  memory write address = low ADDR_WIDTH bits of registered binary pointer.
- wr_ptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, sent to read-domain synchronizer.
- full  output  1  registered; no write accepted while high.
- almost_full  output  1  registered; wr_level >= AFULL_THRESH.
- wr_level  output  ADDR_WIDTH+1  registered fill level, 0..2^ADDR_WIDTH.
- overflow  output  1  sticky write-while-full error (see Configuration).

## Operation
- State: wr_bin (ADDR_WIDTH+1 bits), wr_ptr_gray, full, almost_full, wr_level, overflow.
- wr_bin_next = wr_bin + 1 when wr_inc & ~full, else wr_bin. Arithmetic is modulo 2^(ADDR_WIDTH+1): 2^(ADDR_WIDTH+1)-1 wraps to 0.
- gray_next = wr_bin_next ^ (wr_bin_next >> 1). wr_ptr_gray <= gray_next. Only one bit changes per increment. wr_ptr_gray must be a flop output, never combinational.
- full <= (gray_next == {~rd_ptr_sync[MSB:MSB-1], rd_ptr_sync[MSB-2:0]}). This compares against the next pointer, so full is high in the cycle right after the write that fills the FIFO.
- rd_bin = Gray-to-binary of rd_ptr_sync (XOR prefix from MSB), combinational.
- wr_level <= wr_bin_next - rd_bin, modulo 2^(ADDR_WIDTH+1). This updates every cycle, including cycles with no write.
- almost_full <= (wr_bin_next - rd_bin) >= AFULL_THRESH.
- Requests while full are dropped: wr_en=0 and the pointer holds. Write-while-full is not a stall or error on the handshake.
- Simultaneous write and read-pointer change in one cycle are both reflected in that cycle's registered flags.

## Timing
- Reset (RST low, async): wr_bin=0, wr_ptr_gray=0, full=0, almost_full=0, wr_level=0, overflow=0. Therefore wr_addr=0, and wr_en equals wr_inc.
- Reset mid-burst clears all state immediately, without waiting for a clock edge. First accept after release is at address 0.
- Write latency: an accepted write at edge N updates wr_addr, wr_ptr_gray, full, wr_level and almost_full after edge N.
- Throughput: one write per cycle until full.
- full, wr_level and almost_full are pessimistic. rd_ptr_sync lags the real read pointer by the synchronizer depth, so full clears no earlier than 1 CLK after rd_ptr_sync advances. Reported level may overstate the true level and never understates it.
- rd_ptr_sync must be Gray coded. A multi-bit change between samples is a protocol violation, and the resulting behaviour is undefined.

## Configuration
- Macro: FIFO_WR_OVERFLOW_EN.
- Defined: overflow <= 1 on any edge where wr_inc & full. It stays high until RST.
- Undefined: overflow is tied to 0 and no overflow flop is built. All other behaviour is identical.

## Test plan
All scenarios use ADDR_WIDTH=3 and AFULL_THRESH=6.
- Reset: drive RST=0 mid-clock -> all outputs 0 immediately; wr_addr=0; wr_en follows wr_inc.
- Fill: rd_ptr_sync=0, wr_inc=1 for 8 cycles -> wr_ptr_gray steps 1,3,2,6,7,5,4,C. almost_full rises after the 6th write. full=1 and wr_level=8 after the 8th.
- Write while full: hold wr_inc=1 after fill -> wr_en=0, wr_addr stays 0, wr_ptr_gray stays C. overflow=1 with macro, 0 without.
- Drain: from full, set rd_ptr_sync=4'b0010 (binary 3) with no writes -> next edge full=0, wr_level=5, almost_full=0.
- Wrap: streaming writes with rd_ptr_sync tracking 2 entries behind for 20 writes -> wr_bin wraps 15->0 and wr_ptr_gray goes 8->0. No false full; wr_level stays 2.
- Reset mid-operation: assert RST after 5 writes -> immediate clear. After release, the next write goes to wr_addr=0 with wr_ptr_gray=1.
